pipe_hazard_ctrl: RTL

//   Central stall/flush sequencer for the 5-stage pipeline.
//   - Drives the enable and bubble controls of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers.
//   - Freezes the pipe while a variable-latency data-memory access is pending.
//   - Inserts load-use bubbles and flushes IF_ID on taken branches.
//   - Halts the pipe with a sticky error if memory never acknowledges.

---
 rtl/pipe_hazard_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-wait freeze, load-use bubbles,
// branch flush and sticky memory-timeout error. Optional perf counters under PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  input  logic        id_ex_memread_i,
  input  logic [4:0]  id_ex_rd_i,
  input  logic [4:0]  if_id_rs_i,
  input  logic [4:0]  if_id_rt_i,
  input  logic        branch_taken_i,
  output logic        pc_en_o,
  output logic        if_id_en_o,
  output logic        if_id_flush_o,
  output logic        id_ex_en_o,
  output logic        id_ex_bubble_o,
  output logic        ex_mem_en_o,
  output logic        mem_wb_bubble_o,
  output logic        err_o,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] load_use_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(MEM_TIMEOUT);

  state_t           r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_err;

  logic w_in_err;
  logic w_mem_stall;
  logic w_load_use_raw;
  logic w_load_use;
  logic w_flush;

  assign w_in_err       = (r_state == ST_ERR);
  assign w_mem_stall    = ~w_in_err & mem_req_i & ~mem_ack_i;
  assign w_load_use_raw = id_ex_memread_i & (id_ex_rd_i != 5'd0) &
                          ((id_ex_rd_i == if_id_rs_i) | (id_ex_rd_i == if_id_rt_i));
  assign w_load_use     = w_load_use_raw & ~w_mem_stall & ~w_in_err;
  // Branch operands depend on the pending load, so a load-use bubble suppresses the flush.
  assign w_flush        = branch_taken_i & ~w_load_use & ~w_mem_stall & ~w_in_err;

  // NOTE: every output gets a default before the priority chain so no latch is inferred.
  always_comb begin
    pc_en_o         = 1'b1;
    if_id_en_o      = 1'b1;
    if_id_flush_o   = 1'b0;
    id_ex_en_o      = 1'b1;
    id_ex_bubble_o  = 1'b0;
    ex_mem_en_o     = 1'b1;
    mem_wb_bubble_o = 1'b0;
    if (rst_i) begin
      // Pipe registers reset alongside; keep them loading.
    end else if (w_in_err || w_mem_stall) begin
      pc_en_o         = 1'b0;
      if_id_en_o      = 1'b0;
      id_ex_en_o      = 1'b0;
      ex_mem_en_o     = 1'b0;
      mem_wb_bubble_o = 1'b1;
    end else if (w_load_use) begin
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      id_ex_bubble_o = 1'b1;
    end else if (w_flush) begin
      if_id_flush_o = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_mem_stall) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= CNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (!mem_req_i || mem_ack_i) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == TIMEOUT_V) begin
            r_state <= ST_ERR;
            r_err   <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        ST_ERR: begin
          r_state <= ST_ERR;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  assign err_o = r_err;

`ifdef PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_lu_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_lu_cnt    <= '0;
    end else begin
      if (w_mem_stall && (r_stall_cnt != 32'hFFFF_FFFF)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_load_use && (r_lu_cnt != 32'hFFFF_FFFF))     r_lu_cnt    <= r_lu_cnt + 32'd1;
    end
  end

  assign stall_cycles_o = r_stall_cnt;
  assign load_use_cnt_o = r_lu_cnt;
`else
  assign stall_cycles_o = 32'd0;
  assign load_use_cnt_o = 32'd0;
`endif

endmodule
